// File: rtl/ula_timing_pkg.sv
// ULA video timing constants and the window-membership rule shared by the
// modulo counters of the horizontal and vertical timing chain.
package ula_timing_pkg;

  localparam int unsigned H_TOTAL       = 448;
  localparam int unsigned V_TOTAL       = 312;

  localparam int unsigned H_BLANK_START = 320;
  localparam int unsigned H_BLANK_END   = 415;
  localparam int unsigned H_SYNC_START  = 344;
  localparam int unsigned H_SYNC_END    = 375;

  localparam int unsigned V_BLANK_START = 248;
  localparam int unsigned V_BLANK_END   = 255;
  localparam int unsigned V_SYNC_START  = 248;
  localparam int unsigned V_SYNC_END    = 251;

  // A window whose start lies after its end wraps through zero, so blanking
  // that straddles the end of a line or frame needs only one comparator.
  function automatic logic in_window(input int unsigned v,
                                     input int unsigned startV,
                                     input int unsigned endV);
    if (startV <= endV) begin
      return (v >= startV) && (v <= endV);
    end
    return (v >= startV) || (v <= endV);
  endfunction

endpackage

// File: rtl/video_mod_counter_win_cmp.sv
// Combinational window comparator: flags whether a count value lies inside
// the window [WIN_START, WIN_END], with wrap-around when START > END.
module win_cmp
  import ula_timing_pkg::*;
#(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned WIN_START = 0,
  parameter int unsigned WIN_END   = 0
) (
  input  logic [WIDTH-1:0] i_value,
  output logic             o_inWindow
);

  // Pure range test so the caller can register the result alongside the count.
  always_comb begin
    o_inWindow = in_window(32'(i_value), WIN_START, WIN_END);
  end

endmodule

// File: rtl/video_mod_counter.sv
// Modulo-N video timing counter with enable, synchronous load, terminal
// count / carry for cascading, and two registered compare windows that are
// always aligned with the count value they are shown with.
module video_mod_counter
  import ula_timing_pkg::*;
#(
  parameter int unsigned WIDTH      = 9,
  parameter int unsigned MODULUS    = 448,
  parameter bit          NEG_EDGE   = 1'b1,
  parameter int unsigned WIN0_START = 0,
  parameter int unsigned WIN0_END   = 255,
  parameter int unsigned WIN1_START = 320,
  parameter int unsigned WIN1_END   = 351
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             carry,
  output logic             win0,
  output logic             win1
);

  localparam int unsigned     LAST_INT = MODULUS - 1;
  localparam logic [WIDTH-1:0] LAST    = LAST_INT[WIDTH-1:0];
  localparam logic [WIDTH:0]   MOD_EXT = MODULUS[WIDTH:0];
  localparam logic WIN0_RST = in_window(0, WIN0_START, WIN0_END);
  localparam logic WIN1_RST = in_window(0, WIN1_START, WIN1_END);

  if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_badModulus
    $error("video_mod_counter: MODULUS must lie in 2 .. 2**WIDTH");
  end

  if ((WIN0_START >= MODULUS) || (WIN0_END >= MODULUS) ||
      (WIN1_START >= MODULUS) || (WIN1_END >= MODULUS)) begin : g_badWindow
    $error("video_mod_counter: window bounds must be below MODULUS");
  end

  logic [WIDTH-1:0] r_cnt;
  logic             r_win0;
  logic             r_win1;
  logic [WIDTH-1:0] w_nextCnt;
  logic             w_loadInRange;
  logic             w_win0Next;
  logic             w_win1Next;

  assign w_loadInRange = ({1'b0, load_val} < MOD_EXT);

  // Next count: load beats enable; out-of-range loads clamp to zero and the
  // last count wraps to zero rather than rolling into unused codes.
  always_comb begin
    w_nextCnt = r_cnt;
    if (load) begin
      w_nextCnt = w_loadInRange ? load_val : '0;
    end else if (ce) begin
      w_nextCnt = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  win_cmp #(
    .WIDTH     (WIDTH),
    .WIN_START (WIN0_START),
    .WIN_END   (WIN0_END)
  ) u_win0Cmp (
    .i_value    (w_nextCnt),
    .o_inWindow (w_win0Next)
  );

  win_cmp #(
    .WIDTH     (WIDTH),
    .WIN_START (WIN1_START),
    .WIN_END   (WIN1_END)
  ) u_win1Cmp (
    .i_value    (w_nextCnt),
    .o_inWindow (w_win1Next)
  );

  if (NEG_EDGE) begin : g_negEdge
    // Count and window registers advance together on the falling edge.
    always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
        r_cnt  <= '0;
        r_win0 <= WIN0_RST;
        r_win1 <= WIN1_RST;
      end else begin
        r_cnt  <= w_nextCnt;
        r_win0 <= w_win0Next;
        r_win1 <= w_win1Next;
      end
    end
  end else begin : g_posEdge
    // Count and window registers advance together on the rising edge.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_cnt  <= '0;
        r_win0 <= WIN0_RST;
        r_win1 <= WIN1_RST;
      end else begin
        r_cnt  <= w_nextCnt;
        r_win0 <= w_win0Next;
        r_win1 <= w_win1Next;
      end
    end
  end

  // Carry is masked during a load so reloading this stage never steps the next one.
  assign cnt   = r_cnt;
  assign tc    = (r_cnt == LAST);
  assign carry = tc & ce & ~load;
  assign win0  = r_win0;
  assign win1  = r_win1;

endmodule
